// File: rtl/inst_mem_sync.sv
// rtl/inst_mem_sync.sv - single-port instruction memory with synchronous fetch, program load and power-on clear
//
// Parameters
//   DATA_W    instruction word width in bits
//   DEPTH     number of words (power of two, >= 2)
//   NOP_WORD  value written by the clear sequence and returned on faulting fetches
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst          synchronous active-low reset
//   fetch_req    fetch request
//   fetch_addr   byte address of the fetch
//   fetch_stall  downstream stall, holds the output word
//   fetch_flush  kills the output word
//   fetch_ready  fetch accepted this cycle if fetch_req=1
//   fetch_valid  fetch_data / fetch_fault are valid
//   fetch_data   fetched instruction
//   fetch_fault  fetched address was misaligned or out of range
//   ld_en        program-load write strobe
//   ld_addr      byte address of the load
//   ld_data      word to write
//   ld_ack       one-cycle pulse: the load was written
//   init_busy    memory clear in progress

module inst_mem_sync #(
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 64,
    parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    input  logic              fetch_stall,
    input  logic              fetch_flush,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_fault,
    input  logic              ld_en,
    input  logic [31:0]       ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ack,
    output logic              init_busy
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        state;
    logic [AW-1:0]     clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic          fetch_legal;
    logic          ld_legal;
    logic [AW-1:0] fetch_idx;
    logic [AW-1:0] ld_idx;
    logic          fetch_accept;
    logic          ld_write;
    logic          clearing;

    // Legal means word aligned and every index bit above the array size is zero.
    assign fetch_legal = (fetch_addr[1:0] == 2'b00) && ~|fetch_addr[31:AW+2];
    assign ld_legal    = (ld_addr[1:0] == 2'b00) && ~|ld_addr[31:AW+2];
    assign fetch_idx   = fetch_addr[AW+1:2];
    assign ld_idx      = ld_addr[AW+1:2];

    // Gating with rst keeps the handshake quiet while reset is held, even
    // before the first reset edge has initialised the state register.
    assign fetch_ready  = rst && (state == ST_RUN) && !fetch_stall;
    assign init_busy    = !rst || (state == ST_CLEAR);
    assign fetch_accept = fetch_req && fetch_ready;
    assign ld_write     = rst && (state == ST_RUN) && ld_en && ld_legal;
    assign clearing     = rst && (state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == AW'(DEPTH - 1)) begin
                state <= ST_RUN;
            end
        end
    end

    // Clear and load never overlap: loads are only honoured in RUN.
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[clr_cnt] <= NOP_WORD;
        end else if (ld_write) begin
            mem[ld_idx] <= ld_data;
        end
    end

    // The read below samples mem before this edge's write lands, which gives
    // read-before-write for a same-cycle load and fetch of one word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_data  <= NOP_WORD;
            ld_ack      <= 1'b0;
        end else begin
            ld_ack <= ld_write;
            if (fetch_flush) begin
                fetch_valid <= 1'b0;
                fetch_fault <= 1'b0;
            end else if (fetch_stall) begin
                fetch_valid <= fetch_valid;
            end else if (fetch_accept) begin
                fetch_valid <= 1'b1;
                if (fetch_legal) begin
                    fetch_data  <= mem[fetch_idx];
                    fetch_fault <= 1'b0;
                end else begin
                    fetch_data  <= NOP_WORD;
                    fetch_fault <= 1'b1;
                end
            end else begin
                fetch_valid <= 1'b0;
                fetch_fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_sync.sv
// tb/tb_inst_mem_sync.sv - self-checking bench for inst_mem_sync

module tb_inst_mem_sync;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_stall;
    logic        fetch_flush;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_fault;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_ack;
    logic        init_busy;

    inst_mem_sync #(.DATA_W(32), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_stall(fetch_stall),
        .fetch_flush(fetch_flush),
        .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .fetch_fault(fetch_fault),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ack     (ld_ack),
        .init_busy  (init_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    logic [31:0] m_mem [DEPTH];
    int          m_clear_left = DEPTH;
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = NOP;
    logic        m_fault = 1'b0;
    logic        m_fault_known = 1'b0;
    logic        m_ack   = 1'b0;

    logic s_busy;
    logic s_ready;

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && ((a / 4) < DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance the
    // model at the edge, then check registered outputs on the falling edge.
    task automatic cycle(input logic r, input logic req, input logic [31:0] fa,
                         input logic st, input logic fl, input logic le,
                         input logic [31:0] la, input logic [31:0] ld);
        logic        run;
        logic [31:0] rd;
        rst = r; fetch_req = req; fetch_addr = fa; fetch_stall = st;
        fetch_flush = fl; ld_en = le; ld_addr = la; ld_data = ld;
        #1;
        run = (m_clear_left == 0);
        s_busy  = init_busy;
        s_ready = fetch_ready;
        chk("fetch_ready", fetch_ready, r && run && !st);
        chk("init_busy", init_busy, !r || !run);
        @(posedge clk);
        if (!r) begin
            m_clear_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
            m_valid = 0; m_fault = 0; m_fault_known = 1; m_data = NOP; m_ack = 0;
        end else begin
            rd = legal(fa) ? m_mem[fa / 4] : NOP;
            if (fl) begin
                m_valid = 0; m_fault = 0; m_fault_known = 1;
            end else if (st) begin
                // hold
            end else if (run && req) begin
                m_valid = 1; m_data = rd; m_fault = !legal(fa); m_fault_known = 1;
            end else begin
                m_valid = 0; m_fault_known = 0;
            end
            m_ack = run && le && legal(la);
            if (m_ack) m_mem[la / 4] = ld;
            if (!run) m_clear_left--;
        end
        @(negedge clk);
        chk("fetch_valid", fetch_valid, m_valid);
        chk("ld_ack", ld_ack, m_ack);
        if (m_valid) chk("fetch_data", fetch_data, m_data);
        if (m_fault_known) chk("fetch_fault", fetch_fault, m_fault);
    endtask

    task automatic idle();
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fetch(input logic [31:0] a);
        cycle(1, 1, a, 0, 0, 0, 0, 0);
    endtask

    task automatic count_clear();
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            idle();
            if (!s_busy) break;
            n++;
        end
        chk("clear_cycles", n, 64);
    endtask

    initial begin
        rst = 0; fetch_req = 0; fetch_addr = 0; fetch_stall = 0; fetch_flush = 0;
        ld_en = 0; ld_addr = 0; ld_data = 0;
        @(negedge clk);

        // Reset state
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 1, 0, 32'hdead_beef);
        chk("rst_valid", fetch_valid, 0);
        chk("rst_fault", fetch_fault, 0);
        chk("rst_data", fetch_data, 32'h0);
        chk("rst_ack", ld_ack, 0);
        chk("rst_busy", s_busy, 1);
        chk("rst_ready", s_ready, 0);

        // Clear length, then fetch of a cleared word
        count_clear();
        fetch(32'h10);
        chk("f10_valid", fetch_valid, 1);
        chk("f10_data", fetch_data, 32'h0);
        chk("f10_fault", fetch_fault, 0);

        // Load then fetch
        cycle(1, 0, 0, 0, 0, 1, 32'h0, 32'h8001060A);
        chk("ld0_ack", ld_ack, 1);
        fetch(32'h0);
        chk("f0_data", fetch_data, 32'h8001060A);

        // Illegal addresses
        fetch(32'h100);
        chk("f100_fault", fetch_fault, 1);
        chk("f100_data", fetch_data, 32'h0);
        fetch(32'h6);
        chk("f6_valid", fetch_valid, 1);
        chk("f6_fault", fetch_fault, 1);
        cycle(1, 0, 0, 0, 0, 1, 32'h100, 32'hffff_ffff);
        chk("ld100_ack", ld_ack, 0);

        // Stall hold, then flush during stall
        fetch(32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 32'h4, 1, 0, 0, 0, 0);
            chk("stall_ready", s_ready, 0);
            chk("stall_data", fetch_data, 32'h8001060A);
            chk("stall_valid", fetch_valid, 1);
        end
        cycle(1, 1, 32'h4, 1, 1, 0, 0, 0);
        chk("flush_valid", fetch_valid, 0);

        // Read-before-write
        cycle(1, 1, 32'h4, 0, 0, 1, 32'h4, 32'h12345678);
        chk("rbw_old", fetch_data, 32'h0);
        chk("rbw_ack", ld_ack, 1);
        fetch(32'h4);
        chk("rbw_new", fetch_data, 32'h12345678);

        // Reset mid-run wipes memory
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rrst_valid", fetch_valid, 0);
        chk("rrst_busy", s_busy, 1);
        count_clear();
        fetch(32'h0);
        chk("rrst_f0", fetch_data, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic        r, rq, st, fl, le;
            logic [31:0] fa, la, ld;
            r  = ($urandom_range(0, 399) != 0);
            rq = ($urandom_range(0, 1) == 1);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            le = ($urandom_range(0, 2) == 0);
            fa = $urandom_range(0, DEPTH * 4 + 15);
            la = $urandom_range(0, DEPTH * 4 + 15);
            if ($urandom_range(0, 3) != 0) fa[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) la[1:0] = 2'b00;
            if ($urandom_range(0, 31) == 0) fa = $urandom;
            ld = $urandom;
            cycle(r, rq, fa, st, fl, le, la, ld);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
